// File: rtl/hpdmc_pkg.sv
// Shared definitions for the HPDMC command scheduler: SDRAM command encodings,
// scheduler FSM states and bank geometry.
package hpdmc_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_NOP   = 4'b0111,
    CMD_ACT   = 4'b0011,
    CMD_READ  = 4'b0101,
    CMD_WRITE = 4'b0100,
    CMD_PRE   = 4'b0010,
    CMD_REF   = 4'b0001
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRECHALL,
    S_PRECH,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_COLUMN,
    S_REFRESH,
    S_WAIT_RFC
  } sched_state_e;

  localparam int unsigned NBANKS  = 4;
  localparam int unsigned A10_BIT = 10;

  function automatic logic [NBANKS-1:0] bank_onehot(input logic [1:0] bank);
    logic [NBANKS-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/hpdmc_refreshtimer.sv
// Refresh interval timer: counts down tim_refi cycles and raises a sticky
// pending flag that the scheduler clears when it decides AUTO-REFRESH.
module hpdmc_refreshtimer (
  input  logic        sys_clk,
  input  logic        sdram_rst_n,
  input  logic [10:0] tim_refi,
  input  logic        refresh_done,
  output logic        refresh_pending
);

  logic [10:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        expire;

  always_comb begin
    expire    = (cnt_q == '0);
    cnt_d     = expire ? tim_refi : cnt_q - 11'd1;
    // A fresh expiry wins over a same-cycle clear so no interval is lost.
    pending_d = (pending_q & ~refresh_done) | expire;
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign refresh_pending = pending_q;

endmodule

// File: rtl/hpdmc_cmdsched.sv
// SDRAM command scheduler: per-bank open-row tracking, PRECHARGE/ACTIVATE/
// READ/WRITE/AUTO-REFRESH sequencing gated by the data-control safe flags.
module hpdmc_cmdsched
  import hpdmc_pkg::*;
#(
  parameter int unsigned ROW_W = 13,
  parameter int unsigned COL_W = 10
) (
  input  logic                     sys_clk,
  input  logic                     sdram_rst_n,
  input  logic                     stb,
  input  logic                     we,
  input  logic [ROW_W+2+COL_W-1:0] address,
  output logic                     ack,
  input  logic [2:0]               tim_rp,
  input  logic [2:0]               tim_rcd,
  input  logic [3:0]               tim_rfc,
  input  logic [10:0]              tim_refi,
  input  logic                     read_safe,
  input  logic                     write_safe,
  input  logic [NBANKS-1:0]        precharge_safe,
  output logic                     read,
  output logic                     write,
  output logic [NBANKS-1:0]        concerned_bank,
  output logic                     sdram_cs_n,
  output logic                     sdram_ras_n,
  output logic                     sdram_cas_n,
  output logic                     sdram_we_n,
  output logic [1:0]               sdram_ba,
  output logic [ROW_W-1:0]         sdram_adr
);

  logic [COL_W-1:0] req_col;
  logic [1:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic             req_hit;

  sched_state_e     state_q, state_d;
  logic [NBANKS-1:0] open_q, open_d;
  logic [ROW_W-1:0] row_q [NBANKS];
  logic [ROW_W-1:0] row_d [NBANKS];
  logic [3:0]       wait_q, wait_d;
  logic             rp_to_ref_q, rp_to_ref_d;

  sdram_cmd_e       cmd_q, cmd_d;
  logic [1:0]       ba_q, ba_d;
  logic [ROW_W-1:0] adr_q, adr_d;

  logic             refresh_pending;
  logic             refresh_done;

  hpdmc_refreshtimer u_refreshtimer (
    .sys_clk         (sys_clk),
    .sdram_rst_n     (sdram_rst_n),
    .tim_refi        (tim_refi),
    .refresh_done    (refresh_done),
    .refresh_pending (refresh_pending)
  );

  assign req_col  = address[COL_W-1:0];
  assign req_bank = address[COL_W+1:COL_W];
  assign req_row  = address[ROW_W+COL_W+1:COL_W+2];
  assign req_hit  = open_q[req_bank] && (row_q[req_bank] == req_row);

  always_comb begin
    state_d        = state_q;
    open_d         = open_q;
    row_d          = row_q;
    wait_d         = wait_q;
    rp_to_ref_d    = rp_to_ref_q;
    cmd_d          = CMD_NOP;
    ba_d           = ba_q;
    adr_d          = adr_q;
    ack            = 1'b0;
    read           = 1'b0;
    write          = 1'b0;
    concerned_bank = '0;
    refresh_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (refresh_pending) begin
          state_d = (|open_q) ? S_PRECHALL : S_REFRESH;
        end else if (stb) begin
          if (!open_q[req_bank]) state_d = S_ACT;
          else if (req_hit)      state_d = S_COLUMN;
          else                   state_d = S_PRECH;
        end
      end
      S_PRECHALL: begin
        if (&precharge_safe) begin
          cmd_d          = CMD_PRE;
          ba_d           = '0;
          adr_d          = '0;
          adr_d[A10_BIT] = 1'b1;
          open_d         = '0;
          wait_d         = {1'b0, tim_rp};
          rp_to_ref_d    = 1'b1;
          state_d        = S_WAIT_RP;
        end
      end
      S_PRECH: begin
        if (precharge_safe[req_bank]) begin
          cmd_d            = CMD_PRE;
          ba_d             = req_bank;
          adr_d            = '0;
          open_d[req_bank] = 1'b0;
          wait_d           = {1'b0, tim_rp};
          rp_to_ref_d      = 1'b0;
          state_d          = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (wait_q == '0) state_d = rp_to_ref_q ? S_REFRESH : S_ACT;
        else              wait_d  = wait_q - 4'd1;
      end
      S_ACT: begin
        cmd_d            = CMD_ACT;
        ba_d             = req_bank;
        adr_d            = req_row;
        open_d[req_bank] = 1'b1;
        row_d[req_bank]  = req_row;
        wait_d           = {1'b0, tim_rcd};
        state_d          = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (wait_q == '0) state_d = S_COLUMN;
        else              wait_d  = wait_q - 4'd1;
      end
      S_COLUMN: begin
        if (we ? write_safe : read_safe) begin
          cmd_d          = we ? CMD_WRITE : CMD_READ;
          ba_d           = req_bank;
          adr_d          = ROW_W'(req_col);
          read           = ~we;
          write          = we;
          concerned_bank = bank_onehot(req_bank);
          ack            = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_REFRESH: begin
        cmd_d        = CMD_REF;
        refresh_done = 1'b1;
        wait_d       = tim_rfc;
        state_d      = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (wait_q == '0) state_d = S_IDLE;
        else              wait_d  = wait_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q     <= S_IDLE;
      open_q      <= '0;
      row_q       <= '{default: '0};
      wait_q      <= '0;
      rp_to_ref_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      adr_q       <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      row_q       <= row_d;
      wait_q      <= wait_d;
      rp_to_ref_q <= rp_to_ref_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      adr_q       <= adr_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_ba  = ba_q;
  assign sdram_adr = adr_q;

endmodule

// File: tb/tb_hpdmc_cmdsched.sv
// Scoreboard bench for hpdmc_cmdsched: directed requests push expected pin
// commands and ack pulses with exact cycles; a negedge monitor pops and checks.
module tb_hpdmc_cmdsched;

  localparam int ROW_W = 13;
  localparam int COL_W = 10;
  localparam int AW    = ROW_W + 2 + COL_W;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  logic             clk;
  logic             rst_n;
  logic             stb;
  logic             we;
  logic [AW-1:0]    address;
  logic             ack;
  logic [2:0]       tim_rp;
  logic [2:0]       tim_rcd;
  logic [3:0]       tim_rfc;
  logic [10:0]      tim_refi;
  logic             read_safe;
  logic             write_safe;
  logic [3:0]       psafe;
  logic             read;
  logic             write;
  logic [3:0]       cbank;
  logic             cs_n, ras_n, cas_n, we_n;
  logic [1:0]       ba;
  logic [ROW_W-1:0] adr;

  hpdmc_cmdsched #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .sys_clk        (clk),
    .sdram_rst_n    (rst_n),
    .stb            (stb),
    .we             (we),
    .address        (address),
    .ack            (ack),
    .tim_rp         (tim_rp),
    .tim_rcd        (tim_rcd),
    .tim_rfc        (tim_rfc),
    .tim_refi       (tim_refi),
    .read_safe      (read_safe),
    .write_safe     (write_safe),
    .precharge_safe (psafe),
    .read           (read),
    .write          (write),
    .concerned_bank (cbank),
    .sdram_cs_n     (cs_n),
    .sdram_ras_n    (ras_n),
    .sdram_cas_n    (cas_n),
    .sdram_we_n     (we_n),
    .sdram_ba       (ba),
    .sdram_adr      (adr)
  );

  typedef struct {
    logic [3:0]       cmd;
    logic [1:0]       ba;
    logic [ROW_W-1:0] adr;
    bit               chk_ba;
    bit               chk_adr;
    int               at;
  } cmd_t;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] cb;
    int         at;
  } pls_t;

  cmd_t cmd_sb[$];
  pls_t pls_sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the period between reset release and the first rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  cmd_t       me;
  pls_t       mp;
  logic [3:0] mcmd;

  always @(negedge clk) begin
    if (rst_n) begin
      mcmd = {cs_n, ras_n, cas_n, we_n};
      if (mcmd != C_NOP) begin
        tests++;
        if (cmd_sb.size() == 0) begin
          fails++;
          $display("FAIL cmd_unexpected: got cmd=%b ba=%0d adr=%h at cycle %0d, required NOP", mcmd, ba, adr, cyc);
        end else begin
          me = cmd_sb.pop_front();
          if (mcmd !== me.cmd || (me.chk_ba && ba !== me.ba) || (me.chk_adr && adr !== me.adr) || cyc != me.at) begin
            fails++;
            $display("FAIL cmd_check: got cmd=%b ba=%0d adr=%h cycle=%0d, required cmd=%b ba=%0d adr=%h cycle=%0d",
                     mcmd, ba, adr, cyc, me.cmd, me.ba, me.adr, me.at);
          end
        end
      end
      if (ack || read || write || cbank != 4'b0000) begin
        tests++;
        if (pls_sb.size() == 0) begin
          fails++;
          $display("FAIL pulse_unexpected: got ack=%b rd=%b wr=%b cb=%b at cycle %0d, required none", ack, read, write, cbank, cyc);
        end else begin
          mp = pls_sb.pop_front();
          if (ack !== 1'b1 || read !== mp.rd || write !== mp.wr || cbank !== mp.cb || cyc != mp.at) begin
            fails++;
            $display("FAIL pulse_check: got ack=%b rd=%b wr=%b cb=%b cycle=%0d, required ack=1 rd=%b wr=%b cb=%b cycle=%0d",
                     ack, read, write, cbank, cyc, mp.rd, mp.wr, mp.cb, mp.at);
          end
        end
      end
    end
  end

  task automatic exp_cmd(input logic [3:0] c, input logic [1:0] b, input logic [ROW_W-1:0] a,
                         input bit cb, input bit ca, input int at);
    cmd_t e;
    e.cmd = c; e.ba = b; e.adr = a; e.chk_ba = cb; e.chk_adr = ca; e.at = at;
    cmd_sb.push_back(e);
  endtask

  task automatic exp_pls(input logic rd, input logic wr, input logic [3:0] cb, input int at);
    pls_t p;
    p.rd = rd; p.wr = wr; p.cb = cb; p.at = at;
    pls_sb.push_back(p);
  endtask

  task automatic check_reset(input string name);
    tests++;
    if ({cs_n, ras_n, cas_n, we_n} !== C_NOP || ba !== 2'd0 || adr !== '0 ||
        ack !== 1'b0 || read !== 1'b0 || write !== 1'b0 || cbank !== 4'b0000) begin
      fails++;
      $display("FAIL %s: got cmd=%b ba=%0d adr=%h ack=%b rd=%b wr=%b cb=%b, required cmd=0111 and all zero",
               name, {cs_n, ras_n, cas_n, we_n}, ba, adr, ack, read, write, cbank);
    end
  endtask

  // Called at rising edge + 1; returns at the same phase with the clock at cycle t.
  task automatic wait_cyc(input int t);
    for (int i = 0; i < 4000 && cyc < t; i++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (cyc != t) begin
      fails++;
      $display("FAIL schedule: got cycle %0d, required %0d", cyc, t);
    end
  endtask

  // Presents a request and returns one cycle after ack, with stb dropped.
  task automatic request(input logic w, input logic [1:0] b, input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    bit got;
    got     = 1'b0;
    stb     = 1'b1;
    we      = w;
    address = {r, b, c};
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack within 64 cycles, required ack for bank %0d row %0d", b, r);
    end
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    stb        = 1'b0;
    we         = 1'b0;
    address    = '0;
    tim_rp     = 3'd2;
    tim_rcd    = 3'd2;
    tim_rfc    = 4'd3;
    tim_refi   = 11'd2047;
    read_safe  = 1'b1;
    write_safe = 1'b1;
    psafe      = 4'b1111;

    repeat (3) @(negedge clk);
    check_reset("reset_init");
    exp_cmd(C_REF, 2'd0, '0, 1'b0, 1'b0, 2);
    #1 rst_n = 1'b1;

    // Closed bank read: ACT, tRCD wait, READ.
    wait_cyc(6);
    exp_cmd(C_ACT, 2'd1, 13'd5, 1'b1, 1'b1, 8);
    exp_pls(1'b1, 1'b0, 4'b0010, 11);
    exp_cmd(C_RD, 2'd1, 13'h02A, 1'b1, 1'b1, 12);
    request(1'b0, 2'd1, 13'd5, 10'h02A);

    // Row hit gated by read_safe for four cycles.
    wait_cyc(12);
    read_safe = 1'b0;
    exp_pls(1'b1, 1'b0, 4'b0010, 17);
    exp_cmd(C_RD, 2'd1, 13'h03F, 1'b1, 1'b1, 18);
    fork
      request(1'b0, 2'd1, 13'd5, 10'h03F);
      begin
        repeat (5) @(posedge clk);
        #1 read_safe = 1'b1;
      end
    join

    // Row miss write: PRE gated by precharge_safe[1], WRITE gated by write_safe.
    wait_cyc(18);
    psafe      = 4'b1101;
    write_safe = 1'b0;
    exp_cmd(C_PRE, 2'd1, 13'd0, 1'b1, 1'b1, 23);
    exp_cmd(C_ACT, 2'd1, 13'd9, 1'b1, 1'b1, 27);
    exp_pls(1'b0, 1'b1, 4'b0010, 32);
    exp_cmd(C_WR, 2'd1, 13'h011, 1'b1, 1'b1, 33);
    fork
      request(1'b1, 2'd1, 13'd9, 10'h011);
      begin
        repeat (4) @(posedge clk);
        #1 psafe = 4'b1111;
        repeat (10) @(posedge clk);
        #1 write_safe = 1'b1;
      end
    join

    // Open banks 0 and 2.
    wait_cyc(33);
    exp_cmd(C_ACT, 2'd0, 13'd3, 1'b1, 1'b1, 35);
    exp_pls(1'b1, 1'b0, 4'b0001, 38);
    exp_cmd(C_RD, 2'd0, 13'h005, 1'b1, 1'b1, 39);
    request(1'b0, 2'd0, 13'd3, 10'h005);

    wait_cyc(39);
    exp_cmd(C_ACT, 2'd2, 13'd4, 1'b1, 1'b1, 41);
    exp_pls(1'b0, 1'b1, 4'b0100, 44);
    exp_cmd(C_WR, 2'd2, 13'h007, 1'b1, 1'b1, 45);
    request(1'b1, 2'd2, 13'd4, 10'h007);

    // Zero tRP/tRCD: each wait state still takes one cycle.
    wait_cyc(45);
    tim_rp  = 3'd0;
    tim_rcd = 3'd0;
    exp_cmd(C_PRE, 2'd2, 13'd0, 1'b1, 1'b1, 47);
    exp_cmd(C_ACT, 2'd2, 13'd8, 1'b1, 1'b1, 49);
    exp_pls(1'b0, 1'b1, 4'b0100, 50);
    exp_cmd(C_WR, 2'd2, 13'h001, 1'b1, 1'b1, 51);
    request(1'b1, 2'd2, 13'd8, 10'h001);
    tim_rp   = 3'd2;
    tim_rcd  = 3'd2;
    tim_refi = 11'd20;

    // Timer expires at cycle 2048; request held as refresh becomes pending.
    wait_cyc(2049);
    psafe = 4'b0111;
    exp_cmd(C_PRE, 2'd0, 13'h0400, 1'b0, 1'b1, 2054);
    exp_cmd(C_REF, 2'd0, '0, 1'b0, 1'b0, 2058);
    exp_cmd(C_ACT, 2'd0, 13'd6, 1'b1, 1'b1, 2064);
    exp_pls(1'b1, 1'b0, 4'b0001, 2067);
    exp_cmd(C_RD, 2'd0, 13'h009, 1'b1, 1'b1, 2068);
    fork
      request(1'b0, 2'd0, 13'd6, 10'h009);
      begin
        repeat (4) @(posedge clk);
        #1 psafe = 4'b1111;
      end
    join

    // Asynchronous reset during WAIT_RCD.
    tim_refi = 11'd2047;
    stb      = 1'b1;
    we       = 1'b0;
    address  = {13'd1, 2'd3, 10'd2};
    exp_cmd(C_ACT, 2'd3, 13'd1, 1'b1, 1'b1, 2070);
    wait_cyc(2071);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    stb = 1'b0;
    exp_cmd(C_REF, 2'd0, '0, 1'b0, 1'b0, 2);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(7);

    for (int i = 0; i < 20 && (cmd_sb.size() != 0 || pls_sb.size() != 0); i++) @(negedge clk);
    tests++;
    if (cmd_sb.size() != 0 || pls_sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d commands and %0d pulses outstanding, required 0 and 0", cmd_sb.size(), pls_sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hpdmc_cmdsched.md
Name: hpdmc_cmdsched

Overview:
Command scheduler directly upstream of the HPDMC data-control stage.
- Accepts single memory requests (strobe, address, direction).
- Tracks the open row of each of 4 banks.
- Sequences PRECHARGE/ACTIVATE/READ/WRITE/AUTO-REFRESH on the SDRAM command pins.
- Issues column commands only when the data-control stage reports read_safe/write_safe/precharge_safe.
- Drives that stage's read/write/concerned_bank inputs.

Parameters:
ROW_W, 13, row address width; also width of sdram_adr (must be >= 11).
COL_W, 10, column address width (must be <= 10; A10 is reserved for precharge-all).

Ports:
sys_clk  in  1  system clock
sdram_rst_n  in  1  asynchronous active-low reset
stb  in  1  request valid; held with address/we stable until ack
we  in  1  1 = write request, 0 = read request
address  in  ROW_W+2+COL_W  request address, mapped {row, bank, col}
ack  out  1  one-cycle pulse: column command for the request issued
tim_rp  in  3  tRP in cycles
tim_rcd  in  3  tRCD in cycles
tim_rfc  in  4  tRFC in cycles
tim_refi  in  11  refresh interval in cycles
read_safe  in  1  from data-control stage
write_safe  in  1  from data-control stage
precharge_safe  in  4  per-bank, from data-control stage
read  out  1  READ decided this cycle
write  out  1  WRITE decided this cycle
concerned_bank  out  4  one-hot bank of the current read/write
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  registered SDRAM command
sdram_ba  out  2  registered bank address
sdram_adr  out  ROW_W  registered row/column address

Behaviour:
- Reset (asynchronous, sdram_rst_n=0):
  - Command = NOP (cs_n=0, ras_n=cas_n=we_n=1); sdram_ba=0; sdram_adr=0.
  - ack=read=write=0; concerned_bank=0.
  - All banks closed; FSM=IDLE; refresh counter=0; refresh_pending=1, so one refresh follows reset.
  - Reset mid-operation abandons the request silently; requester must re-present it.
- Decision timing:
  - FSM decides in cycle n; the command appears on sdram_* at n+1 (registered).
  - read/write/concerned_bank/ack are asserted combinationally in cycle n, so the data-control stage lowers its safe flags from n+1.
  - At most one non-NOP command per cycle; all other cycles drive NOP.
- Refresh timer:
  - Decrements every cycle; at 0 it reloads tim_refi and sets refresh_pending.
  - refresh_pending is cleared when REFRESH is decided.
  - Expiry while already pending: no additional effect.
- States:
  - IDLE:
    - If refresh_pending (priority over stb): go to PRECHALL if any bank is open, else REFRESH.
    - Else if stb: same-row open bank → COLUMN; different-row open bank → PRECH; closed bank → ACT.
  - PRECHALL: wait until precharge_safe==4'b1111, then decide PRECHARGE with A10=1; mark all banks closed; load wait=tim_rp; go to WAIT_RP, next REFRESH.
  - PRECH: wait until precharge_safe[bank]=1, then decide PRECHARGE with A10=0 and ba=bank; mark the bank closed; load wait=tim_rp; go to WAIT_RP, next ACT.
  - WAIT_RP: leave when wait==0, decrementing each cycle; tim_rp=0 → leave in the next cycle.
  - ACT: decide ACTIVATE with adr=row; record open row; load wait=tim_rcd; go to WAIT_RCD.
  - WAIT_RCD: same counting rule as WAIT_RP; then go to COLUMN.
  - COLUMN:
    - Read requests wait for read_safe=1; write requests wait for write_safe=1.
    - Then decide READ/WRITE with adr={zero-padded col, A10=0} and ba=bank.
    - In the same cycle pulse read or write, concerned_bank=1<<bank, and ack; go to IDLE.
  - REFRESH: decide AUTO-REFRESH; load wait=tim_rfc; go to WAIT_RFC.
  - WAIT_RFC: same counting rule; then go to IDLE.
- A new request is never accepted in the cycle ack is asserted; IDLE re-evaluates on the following cycle.
- Back-to-back hits: consecutive column commands are at least 2 cycles apart; the safe flags gate any further spacing.
- stb deasserted before ack is a protocol violation; behaviour is unspecified.

Decomposition:
- Package hpdmc_pkg holds:
  - SDRAM command encodings: NOP, ACT, READ, WRITE, PRE, REF.
  - FSM state enum.
  - Bank count constant (4) and A10 bit index.
- Sub-module hpdmc_refreshtimer contains the tim_refi down-counter and the pending flag. It has inputs sys_clk, sdram_rst_n, tim_refi and refresh_done, and output refresh_pending.

Test Plan:
- Reset release, tim_rfc=3 → REFRESH on pins at cycle 2, then NOP ≥3 cycles, then IDLE; no PRECHARGE issued, since all banks start closed.
- Read of bank 1, row 5 (closed), tim_rcd=2, read_safe=1 → ACT(ba=1, adr=5), NOP×2, READ(ba=1); read and ack pulse with concerned_bank=4'b0010 one cycle before READ on pins.
- Second read, bank 1, row 5 (hit), read_safe held 0 for 4 cycles → no command while low; READ is decided on the first cycle read_safe=1, with no ACT.
- Write, bank 1, row 9 (miss), precharge_safe[1]=0 for 3 cycles, tim_rp=2 → PRE (A10=0, ba=1) only after precharge_safe[1]=1; then ACT(row 9), then WRITE gated by write_safe; write pulse issued.
- tim_refi=20 with banks 0 and 2 open and stb held → PRE with A10=1 after precharge_safe=4'b1111; REFRESH follows tRP; the pending request completes after tRFC, starting from ACT.
- Assert sdram_rst_n low during WAIT_RCD → outputs return to NOP/0 immediately (asynchronous); after release, the first command is REFRESH.
